// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle ALU sequencer: instruction IDs,
// instruction classes, FSM states and the ID-to-class decode.
package alu_seq_pkg;

    localparam logic [31:0] ID_ADD  = 32'd1;
    localparam logic [31:0] ID_ADDI = 32'd5;
    localparam logic [31:0] ID_ORI  = 32'd10;
    localparam logic [31:0] ID_LW   = 32'd13;
    localparam logic [31:0] ID_SW   = 32'd14;
    localparam logic [31:0] ID_J    = 32'd21;
    localparam logic [31:0] ID_SLT  = 32'd24;
    localparam logic [31:0] ID_AND  = 32'd25;

    typedef enum logic [2:0] {
        CLS_RTYPE, CLS_ITYPE, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_ILLEGAL
    } cls_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    function automatic cls_t id_to_class(input logic [31:0] id);
        case (id)
            ID_ADD, ID_SLT, ID_AND: return CLS_RTYPE;
            ID_ADDI, ID_ORI:        return CLS_ITYPE;
            ID_LW:                  return CLS_LOAD;
            ID_SW:                  return CLS_STORE;
            ID_J:                   return CLS_JUMP;
            default:                return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// Memory-wait watchdog: counts enabled cycles since the last clear and flags
// the cycle that is the LIMIT-th one; the count saturates there.
module alu_seq_watchdog #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM sequencing fetch/decode/exec/mem/writeback over the
// shared ALU, register file and data memory, one instruction at a time.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      instr_id,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_src_imm,
    output logic             alu_out_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t state, state_nxt;
    cls_t   cls;
    logic   retire, set_err, wd_expired;
    state_t boundary;

    alu_seq_watchdog #(.LIMIT(MEM_TIMEOUT), .W(TO_W)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_EXEC),
        .en     (state == ST_MEM),
        .expired(wd_expired)
    );

    assign boundary = stop ? ST_IDLE : ST_FETCH;
    assign busy     = (state != ST_IDLE) && (state != ST_HALT);
    assign halted   = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cls         <= CLS_ILLEGAL;
            err         <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE)
                cls <= id_to_class(instr_id);
            if (set_err)
                err <= 1'b1;
            if (retire)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        alu_src_imm = 1'b0;
        alu_out_we  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 1'b0;
        retire      = 1'b0;
        set_err     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (id_to_class(instr_id) == CLS_ILLEGAL) begin
                    set_err   = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls == CLS_JUMP) begin
                    pc_we     = 1'b1;
                    pc_src    = 1'b1;
                    retire    = 1'b1;
                    state_nxt = boundary;
                end else begin
                    alu_out_we  = 1'b1;
                    alu_src_imm = (cls != CLS_RTYPE);
                    state_nxt   = (cls == CLS_LOAD || cls == CLS_STORE) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                // A completion on the watchdog's final cycle still wins.
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        retire    = 1'b1;
                        state_nxt = boundary;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (wd_expired) begin
                    set_err   = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                rf_wsel   = (cls == CLS_LOAD);
                retire    = 1'b1;
                state_nxt = boundary;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed, table-driven bench for alu_seq_ctrl with hand-written sequences
// for back-to-back issue, halt stickiness, counter wrap and mid-MEM reset.
module tb_alu_seq_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n, start, stop, mem_ready;
    logic [31:0]      instr_id;
    logic             ir_we, pc_we, pc_src, alu_src_imm, alu_out_we;
    logic             mem_req, mem_we, rf_we, rf_wsel, busy, halted, err;
    logic [CNT_W-1:0] retired_cnt;
    logic [11:0]      outs;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign outs = {ir_we, pc_we, pc_src, alu_src_imm, alu_out_we, mem_req,
                   mem_we, rf_we, rf_wsel, busy, halted, err};

    alu_seq_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .instr_id(instr_id), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_imm(alu_src_imm), .alu_out_we(alu_out_we),
        .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .busy(busy), .halted(halted), .err(err), .retired_cnt(retired_cnt)
    );

    typedef struct {
        logic [31:0] id;
        int wait_c;   // mem_ready wait cycles, -1 = never
        int lat;      // FETCH entry to retire, 0 = never retires
        int ir, alu, rf, mreq;
        int imm, wsel, mwe, jmp, halt, er;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; instr_id = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n_ir = 0, n_alu = 0, n_rf = 0, m = 0, n_jmp = 0, viol = 0, lat = 0;
        int imm = 0, wsel = 0, mwe = 0;
        string p;
        p = $sformatf("v%0d id%0d", idx, v.id);
        stop = 1'b1; instr_id = v.id; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            if (ir_we) n_ir++;
            if (alu_out_we) begin n_alu++; imm |= alu_src_imm; end
            if (rf_we) begin n_rf++; wsel |= rf_wsel; end
            if (pc_we && pc_src) n_jmp++;
            if (mem_req) begin m++; mwe |= mem_we; end
            if ($countones({ir_we, alu_out_we, rf_we, mem_req}) > 1) viol++;
            if (lat == 0 && retired_cnt != 0) lat = k - 1;
            mem_ready = mem_req && v.wait_c >= 0 && m == v.wait_c + 1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check({p, " latency"}, lat, v.lat);
        check({p, " ir_we cycles"}, n_ir, v.ir);
        check({p, " alu_out_we cycles"}, n_alu, v.alu);
        check({p, " rf_we cycles"}, n_rf, v.rf);
        check({p, " mem_req cycles"}, m, v.mreq);
        check({p, " alu_src_imm"}, imm, v.imm);
        check({p, " rf_wsel"}, wsel, v.wsel);
        check({p, " mem_we"}, mwe, v.mwe);
        check({p, " jump pc_we"}, n_jmp, v.jmp);
        check({p, " halted"}, int'(halted), v.halt);
        check({p, " err"}, int'(err), v.er);
        check({p, " busy end"}, int'(busy), 0);
        check({p, " strobe overlap"}, viol, 0);
        check({p, " retired_cnt"}, int'(retired_cnt), (v.lat != 0) ? 1 : 0);
    endtask

    initial begin
        int seen;
        tbl[0]  = '{32'd1,  -1,  4, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{32'd24, -1,  4, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{32'd25, -1,  4, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{32'd5,  -1,  4, 1, 1, 1,  0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{32'd10, -1,  4, 1, 1, 1,  0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{32'd13,  3,  8, 1, 1, 1,  4, 1, 1, 0, 0, 0, 0};
        tbl[6]  = '{32'd13,  0,  5, 1, 1, 1,  1, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{32'd14,  2,  6, 1, 1, 0,  3, 1, 0, 1, 0, 0, 0};
        tbl[8]  = '{32'd14, 15, 19, 1, 1, 0, 16, 1, 0, 1, 0, 0, 0};
        tbl[9]  = '{32'd14, -1,  0, 1, 1, 0, 16, 1, 0, 1, 0, 1, 1};
        tbl[10] = '{32'd13, -1,  0, 1, 1, 0, 16, 1, 0, 0, 0, 1, 1};
        tbl[11] = '{32'd21, -1,  3, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        tbl[12] = '{32'd7,  -1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1};
        tbl[13] = '{32'd0,  -1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1};
        tbl[14] = '{32'd26, -1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1};

        // Reset state, both while held and after release.
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; instr_id = '0;
        @(negedge clk);
        check("reset held outputs", int'(outs), 0);
        check("reset held retired_cnt", int'(retired_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset released outputs", int'(outs), 0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            run_vec(i, tbl[i]);
        end

        // HALT after timeout ignores start.
        do_reset();
        run_vec(9, tbl[9]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (ir_we || busy || !halted) seen++;
            @(negedge clk);
        end
        check("halt ignores start", seen, 0);
        check("halt retired_cnt", int'(retired_cnt), 0);

        // Back-to-back with stop low, then stop high at the second boundary.
        do_reset();
        instr_id = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b refetch ir_we", int'(ir_we), 1);
        check("b2b first retire", int'(retired_cnt), 1);
        stop = 1'b1;
        repeat (4) @(negedge clk);
        check("b2b stop busy", int'(busy), 0);
        check("b2b second retire", int'(retired_cnt), 2);

        // Reset in the middle of a memory wait.
        instr_id = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        check("mid-MEM reached", int'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        check("mid-MEM reset mem_req", int'(mem_req), 0);
        check("mid-MEM reset outputs", int'(outs), 0);
        check("mid-MEM reset retired_cnt", int'(retired_cnt), 0);

        // retired_cnt wraps after 2^CNT_W back-to-back jumps.
        do_reset();
        instr_id = 32'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 24) check("wrap before", int'(retired_cnt), 7);
            if (k == 25) check("wrap after", int'(retired_cnt), 0);
            if (k < 25) @(negedge clk);
        end
        stop = 1'b1;
        repeat (4) @(negedge clk);
        check("wrap stop idle busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle control FSM that sequences the shared ALU datapath, register file and data memory, one instruction at a time.
- Consumes the decoded instruction ID from the decoder and drives register, mux, ALU-latch and memory strobes.
- Sits between the instruction decoder and the `alu_top` / register-file / memory datapath.
- Owns the retired-instruction counter and the memory-timeout watchdog.

Parameters:
- CNT_W, 32: width of retired_cnt.
- MEM_TIMEOUT, 16: max cycles mem_req stays high without mem_ready before error halt; must be ≥1.
- TO_W, 5: watchdog counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; leave IDLE.
- stop  in  1  level; sampled at instruction boundary; return to IDLE.
- instr_id  in  32  decoded instruction ID; valid in DECODE.
- mem_ready  in  1  data-memory completion; one-cycle pulse.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  1  0 = PC+1, 1 = jump target.
- alu_src_imm  out  1  ALU operand 2: 0 = register rt, 1 = sign-extended immediate.
- alu_out_we  out  1  latch ALU rd into ALU output register.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store; valid only with mem_req.
- rf_we  out  1  register-file write.
- rf_wsel  out  1  write data select: 0 = ALU out, 1 = memory data.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky; set on illegal ID or memory timeout.
- retired_cnt  out  CNT_W  instructions completed; wraps.

Behaviour:
Reset:
- All outputs 0; state = IDLE; retired_cnt = 0; watchdog = 0.
- Asserting rst_n low mid-instruction drops mem_req / rf_we immediately and abandons the instruction (not counted).

Instruction classes by ID (from shared package):
- RTYPE: add = 1, slt = 24, and = 25.
- ITYPE: addi = 5, ori = 10.
- LOAD: lw = 13.
- STORE: sw = 14.
- JUMP: j = 21.
- Every other ID, including 0, is ILLEGAL.

States and per-state actions (outputs are Moore, decoded from state plus the registered class):
- IDLE: start = 1 → FETCH; stop is ignored in IDLE.
- FETCH: ir_we = 1, pc_we = 1, pc_src = 0 → DECODE.
- DECODE: register instr_id class → EXEC; if ILLEGAL → HALT and set err.
- EXEC:
  - RTYPE / ITYPE / LOAD / STORE: alu_out_we = 1; alu_src_imm = 1 for ITYPE / LOAD / STORE, else 0.
  - RTYPE / ITYPE → WB; LOAD / STORE → MEM.
  - JUMP: pc_we = 1, pc_src = 1, alu_out_we = 0, retire → boundary.
- MEM:
  - mem_req = 1; mem_we = 1 for STORE. Watchdog increments every MEM cycle.
  - On mem_ready: STORE retires → boundary; LOAD → WB.
  - Watchdog reaching MEM_TIMEOUT with no mem_ready → HALT, err = 1, mem_req drops the next cycle.
  - mem_ready on the same cycle the watchdog hits the limit counts as success.
  - Watchdog clears on MEM entry.
- WB: rf_we = 1; rf_wsel = 1 for LOAD else 0; retire → boundary.
- Boundary (next state after a retire): stop = 1 → IDLE, else FETCH.
- HALT: all strobes 0, halted = 1; exit only via reset. start is ignored.

Latency from FETCH entry to retire:
- RTYPE / ITYPE: 4 cycles.
- JUMP: 3 cycles.
- STORE: 4 + w cycles, where w = number of mem_ready wait cycles.
- LOAD: 5 + w cycles.

Other rules:
- mem_ready outside MEM is ignored.
- retired_cnt increments by exactly 1 per retire and wraps from 2^CNT_W−1 to 0.
- At most one of ir_we / alu_out_we / rf_we / mem_req is high in any cycle.

Decomposition:
- Package alu_seq_pkg holds:
  - instruction-ID localparams (1, 5, 10, 13, 14, 21, 24, 25);
  - class enum {RTYPE, ITYPE, LOAD, STORE, JUMP, ILLEGAL};
  - state enum;
  - function id_to_class.
- One sub-module, alu_seq_watchdog: a loadable timeout counter with clear, enable and expired outputs.

Test Plan:
- Reset, pulse start, instr_id = 1 (add) → ir_we @ FETCH, alu_out_we @ EXEC with alu_src_imm = 0, rf_we / rf_wsel = 0 @ WB; retired_cnt = 1 after 4 cycles.
- instr_id = 13 (lw), mem_ready after 3 wait cycles → mem_req high 4 cycles, mem_we = 0, then rf_we with rf_wsel = 1; 8 cycles total.
- instr_id = 14 (sw), mem_ready never asserted, MEM_TIMEOUT = 16 → mem_req high exactly 16 cycles, then halted = 1, err = 1; retired_cnt unchanged; start ignored afterwards.
- instr_id = 21 (j) → pc_we with pc_src = 1 in EXEC, no alu_out_we / rf_we; 3-cycle retire; stop held high → IDLE, busy = 0.
- instr_id = 7 (illegal) → HALT directly from DECODE, err = 1, no strobes fired.
- Assert rst_n low mid-MEM → mem_req low immediately; all outputs 0; retired_cnt = 0.
